alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_pipe_if.sv | 35 +++
 rtl/alu_core.sv | 49 ++++
 rtl/alu_pipe.sv | 100 ++++++++++
 tb/tb_alu_pipe.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the execute pipe, decoder and reservation station.
// Holds the default operand/tag widths, the opcode width and the opcode encoding.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned TAG_W_DEFAULT = 3;
    localparam int unsigned OP_W          = 5;

    typedef enum logic [OP_W-1:0] {
        OpAdd  = 5'b00000,
        OpAnd  = 5'b00001,
        OpOr   = 5'b00010,
        OpSll  = 5'b00011,
        OpSrl  = 5'b00100,
        OpSlt  = 5'b00101,
        OpSltu = 5'b00110,
        OpSra  = 5'b00111,
        OpSub  = 5'b01000,
        OpXor  = 5'b01001,
        OpEq   = 5'b01010,
        OpGe   = 5'b01011,
        OpNe   = 5'b01100,
        OpGeu  = 5'b01101,
        OpJalr = 5'b10001,
        OpLt   = 5'b11010,
        OpLtu  = 5'b11011
    } alu_op_e;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue and writeback handshake bundle of the ALU pipe.
//   in_*  : issue side (valid/ready, operands, opcode, destination tag, branch flag)
//   out_* : writeback side (valid/ready, result, destination tag, branch flag)
// master: the issuer / writeback consumer. slave: the ALU pipe itself.
interface alu_pipe_if #(
    parameter int unsigned XLEN  = alu_pkg::XLEN_DEFAULT,
    parameter int unsigned TAG_W = alu_pkg::TAG_W_DEFAULT
);
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_a;
    logic [XLEN-1:0]      in_b;
    logic [OP_W-1:0]      in_op;
    logic [TAG_W-1:0]     in_tag;
    logic                 in_is_branch;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_is_branch;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, in_is_branch, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_is_branch
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, in_is_branch, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_is_branch
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b   : operands (XLEN bits)
//   op     : opcode in alu_pkg encoding
//   result : XLEN-bit result; unknown opcodes yield zero
import alu_pkg::*;

module alu_core #(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic [XLEN-1:0] result
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;
    logic           eq;

    assign shamt = b[ShW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        case (op)
            OpAdd, OpJalr: result = a + b;
            OpSub:         result = a - b;
            OpAnd:         result = a & b;
            OpOr:          result = a | b;
            OpXor:         result = a ^ b;
            OpSll:         result = a << shamt;
            OpSrl:         result = a >> shamt;
            OpSra:         result = $unsigned($signed(a) >>> shamt);
            OpSlt, OpLt:   result = {{(XLEN-1){1'b0}}, lt_s};
            OpSltu, OpLtu: result = {{(XLEN-1){1'b0}}, lt_u};
            OpGe:          result = {{(XLEN-1){1'b0}}, ~lt_s};
            OpGeu:         result = {{(XLEN-1){1'b0}}, ~lt_u};
            OpEq:          result = {{(XLEN-1){1'b0}}, eq};
            OpNe:          result = {{(XLEN-1){1'b0}}, ~eq};
            default:       result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU execute pipe with valid/ready on both sides.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears valids and output tag/branch)
//   flush : synchronous pipeline kill; drops everything in flight and the same-cycle issue
//   bus   : alu_pipe_if.slave -- issue handshake in, writeback handshake out
// S1 registers the issued operation, alu_core computes between S1 and S2, S2 holds the
// writeback. Latency 2, throughput 1/cycle; two entries of buffering under backpressure.
import alu_pkg::*;

module alu_pipe #(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_pipe_if.slave   bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic [XLEN-1:0]  s1_a_q, s1_a_d;
    logic [XLEN-1:0]  s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_br_q, s1_br_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_br_q, s2_br_d;

    logic             s1_adv;
    logic             accept;
    logic [XLEN-1:0]  core_result;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (core_result)
    );

    // in_ready deliberately ignores flush: flush only masks the accept.
    assign s1_adv       = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid_q || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    always_comb begin
        s1_valid_d  = accept || (s1_valid_q && !s1_adv);
        s1_op_d     = accept ? bus.in_op        : s1_op_q;
        s1_a_d      = accept ? bus.in_a         : s1_a_q;
        s1_b_d      = accept ? bus.in_b         : s1_b_q;
        s1_tag_d    = accept ? bus.in_tag       : s1_tag_q;
        s1_br_d     = accept ? bus.in_is_branch : s1_br_q;

        s2_valid_d  = s1_adv || (s2_valid_q && !bus.out_ready);
        s2_result_d = s1_adv ? core_result : s2_result_q;
        // Tag and branch flag read as zero whenever the output slot is empty.
        s2_tag_d    = s1_adv ? s1_tag_q : (s2_valid_d ? s2_tag_q : '0);
        s2_br_d     = s1_adv ? s1_br_q  : (s2_valid_d && s2_br_q);
    end

    // Control state: reset wins over flush, flush wins over accept/advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_br_q    <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_br_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_br_q    <= s2_br_d;
        end
    end

    // Data payload needs no reset; it is only observed behind a valid.
    always_ff @(posedge clk) begin
        s1_op_q     <= s1_op_d;
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_tag_q    <= s1_tag_d;
        s1_br_q     <= s1_br_d;
        s2_result_q <= s2_result_d;
    end

    assign bus.out_valid     = s2_valid_q;
    assign bus.out_result    = s2_result_q;
    assign bus.out_tag       = s2_tag_q;
    assign bus.out_is_branch = s2_br_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (XLEN=32 instance plus an XLEN=64 instance).
// A queue-based model of a 2-entry in-order pipe predicts every output each cycle.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic flush64;

    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(32), .TAG_W(3)) bus ();
    alu_pipe_if #(.XLEN(64), .TAG_W(3)) bus64 ();

    alu_pipe #(.XLEN(32), .TAG_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    alu_pipe #(.XLEN(64), .TAG_W(3)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush64),
        .bus   (bus64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget (t=%0t)", name, $time);
    endtask

    // Reference ALU from the opcode table, written with plain unsigned arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic        slt;
        logic        sltu;
        sh   = 32'(b[4:0]);
        sltu = a < b;
        slt  = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (op)
            5'b00000, 5'b10001: return a + b;
            5'b00001:           return a & b;
            5'b00010:           return a | b;
            5'b00011:           return a << sh;
            5'b00100:           return a >> sh;
            5'b00101, 5'b11010: return {31'b0, slt};
            5'b00110, 5'b11011: return {31'b0, sltu};
            5'b00111:           return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            5'b01000:           return a - b;
            5'b01001:           return a ^ b;
            5'b01010:           return {31'b0, a == b};
            5'b01011:           return {31'b0, !slt};
            5'b01100:           return {31'b0, a != b};
            5'b01101:           return {31'b0, !sltu};
            default:            return 32'h0;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  tag;
        logic        br;
    } txn_t;

    // Model: in-order queue of at most 2 results; 'shown' says the head is on the output.
    txn_t mq[$];
    bit   shown = 1'b0;
    bit   live  = 1'b0;

    initial begin : model_proc
        txn_t t;
        int   kept;
        bit   can_take;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                shown = 1'b0;
                live  = 1'b1;
            end else if (flush) begin
                mq.delete();
                shown = 1'b0;
            end else begin
                can_take = (mq.size() < 2) || (bus.out_ready == 1'b1);
                if (shown && bus.out_ready) void'(mq.pop_front());
                kept = mq.size();
                if (bus.in_valid && can_take) begin
                    t.res = ref_alu(bus.in_op, bus.in_a, bus.in_b);
                    t.tag = bus.in_tag;
                    t.br  = bus.in_is_branch;
                    mq.push_back(t);
                end
                // Anything already held before this edge reaches the output slot now.
                shown = kept > 0;
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (live) begin
                check("out_valid", {63'b0, bus.out_valid}, {63'b0, shown});
                check("in_ready", {63'b0, bus.in_ready},
                      {63'b0, (mq.size() < 2) || (bus.out_ready == 1'b1)});
                if (shown) begin
                    check("out_result", {32'b0, bus.out_result}, {32'b0, mq[0].res});
                    check("out_tag", {61'b0, bus.out_tag}, {61'b0, mq[0].tag});
                    check("out_is_branch", {63'b0, bus.out_is_branch}, {63'b0, mq[0].br});
                end else begin
                    check("idle_tag", {61'b0, bus.out_tag}, 64'h0);
                    check("idle_branch", {63'b0, bus.out_is_branch}, 64'h0);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] tag, input logic br);
        bit   done;
        logic rdy;
        done             = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_op        = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_tag       = tag;
        bus.in_is_branch = br;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!done) timeout_fail("issue");
    endtask

    task automatic wait_out(output logic [31:0] res, output logic [2:0] tag);
        bit found;
        found = 1'b0;
        res   = '0;
        tag   = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1;
                res   = bus.out_result;
                tag   = bus.out_tag;
            end
        end
        @(posedge clk);
        #1;
        if (!found) timeout_fail("wait_out");
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  st_op [4];
    logic [31:0] st_a  [4];
    logic [31:0] st_b  [4];

    initial begin : stim
        logic [31:0] r;
        logic [2:0]  tg;
        logic [2:0]  dq[$];
        logic        rdy;
        int          k;
        int          seen;
        logic [31:0] specials [5];

        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        st_op = '{5'b00000, 5'b01001, 5'b01000, 5'b00010};
        st_a  = '{32'd1, 32'hF0, 32'd10, 32'h100};
        st_b  = '{32'd2, 32'hFF, 32'd3, 32'h1};

        rst = 1'b1;
        flush = 1'b0;
        flush64 = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.in_is_branch = 1'b0;
        bus.out_ready = 1'b1;
        bus64.in_valid = 1'b0;
        bus64.in_op = '0;
        bus64.in_a = '0;
        bus64.in_b = '0;
        bus64.in_tag = '0;
        bus64.in_is_branch = 1'b0;
        bus64.out_ready = 1'b1;

        // Pin the reference model itself.
        check("model_sra", {32'b0, ref_alu(5'b00111, 32'h8000_0000, 32'h24)}, 64'hF800_0000);
        check("model_slt", {32'b0, ref_alu(5'b00101, 32'hFFFF_FFFF, 32'h0)}, 64'h1);
        check("model_bad_op", {32'b0, ref_alu(5'b11111, 32'h5, 32'h6)}, 64'h0);

        repeat (2) cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'b0, bus.out_valid}, 64'h0);
        check("reset_out_tag", {61'b0, bus.out_tag}, 64'h0);
        check("reset_in_ready", {63'b0, bus.in_ready}, 64'h1);
        cycle();

        // ADD wrap, latency 2.
        issue(5'b00000, 32'hFFFF_FFFF, 32'h1, 3'd5, 1'b0);
        @(negedge clk);
        check("add_lat1_valid", {63'b0, bus.out_valid}, 64'h0);
        @(negedge clk);
        check("add_lat2_valid", {63'b0, bus.out_valid}, 64'h1);
        check("add_result", {32'b0, bus.out_result}, 64'h0);
        check("add_tag", {61'b0, bus.out_tag}, 64'h5);
        cycle();

        issue(5'b00111, 32'h8000_0000, 32'h24, 3'd1, 1'b0);
        wait_out(r, tg);
        check("sra_result", {32'b0, r}, 64'hF800_0000);
        issue(5'b00101, 32'hFFFF_FFFF, 32'h0, 3'd2, 1'b1);
        wait_out(r, tg);
        check("slt_result", {32'b0, r}, 64'h1);
        issue(5'b00110, 32'hFFFF_FFFF, 32'h0, 3'd3, 1'b0);
        wait_out(r, tg);
        check("sltu_result", {32'b0, r}, 64'h0);
        issue(5'b01101, 32'hFFFF_FFFF, 32'h0, 3'd4, 1'b1);
        wait_out(r, tg);
        check("geu_result", {32'b0, r}, 64'h1);
        check("geu_tag", {61'b0, tg}, 64'h4);

        // Four back-to-back ops, backpressure during cycles 3..5.
        k = 0;
        for (int c = 0; c < 16; c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            if (k < 4) begin
                bus.in_valid     = 1'b1;
                bus.in_op        = st_op[k];
                bus.in_a         = st_a[k];
                bus.in_b         = st_b[k];
                bus.in_tag       = 3'(k + 1);
                bus.in_is_branch = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            rdy = bus.in_ready;
            if (c == 3 || c == 4) begin
                check("bp_in_ready", {63'b0, rdy}, 64'h0);
                check("bp_hold_result", {32'b0, bus.out_result}, 64'h0F);
                check("bp_hold_tag", {61'b0, bus.out_tag}, 64'h2);
            end
            if (bus.out_valid && bus.out_ready) dq.push_back(bus.out_tag);
            @(posedge clk);
            if (bus.in_valid && rdy) k++;
            #1;
        end
        bus.in_valid = 1'b0;
        check("stream_count", 64'(dq.size()), 64'd4);
        for (int i = 0; i < dq.size(); i++) check("stream_order", {61'b0, dq[i]}, 64'(i + 1));

        // Flush with two in flight plus a same-cycle issue.
        bus.out_ready = 1'b0;
        issue(5'b00000, 32'd7, 32'd8, 3'd1, 1'b0);
        issue(5'b00001, 32'hFF, 32'h0F, 3'd2, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_op = 5'b00010;
        bus.in_tag = 3'd3;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {63'b0, bus.out_valid}, 64'h0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_nothing_appears", 64'(seen), 64'd0);
        cycle();

        // Reset with both stages full under backpressure.
        bus.out_ready = 1'b0;
        issue(5'b01000, 32'd9, 32'd4, 3'd6, 1'b1);
        issue(5'b01001, 32'h3, 32'h5, 3'd7, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {63'b0, bus.out_valid}, 64'h0);
        check("midrst_out_tag", {61'b0, bus.out_tag}, 64'h0);
        check("midrst_in_ready", {63'b0, bus.in_ready}, 64'h1);
        bus.out_ready = 1'b1;
        cycle();
        issue(5'b00001, 32'hF0F0, 32'hFF00, 3'd6, 1'b0);
        wait_out(r, tg);
        check("post_rst_result", {32'b0, r}, 64'hF000);
        check("post_rst_tag", {61'b0, tg}, 64'h6);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst              = ($urandom_range(0, 199) == 0);
            flush            = ($urandom_range(0, 39) == 0);
            bus.out_ready    = ($urandom_range(0, 3) != 0);
            bus.in_valid     = ($urandom_range(0, 9) < 7);
            bus.in_op        = ($urandom_range(0, 7) == 0) ? 5'($urandom)
                                                           : st_rand_op($urandom_range(0, 16));
            bus.in_a         = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)]
                                                           : $urandom;
            bus.in_b         = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)]
                                                           : $urandom;
            bus.in_tag       = 3'($urandom);
            bus.in_is_branch = 1'($urandom);
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();

        // XLEN=64 instance: wide shift and unknown opcode.
        @(negedge clk);
        check("x64_in_ready", {63'b0, bus64.in_ready}, 64'h1);
        cycle();
        bus64.in_valid = 1'b1;
        bus64.in_op = 5'b00011;
        bus64.in_a = 64'h1;
        bus64.in_b = 64'd63;
        bus64.in_tag = 3'd1;
        cycle();
        bus64.in_op = 5'b11111;
        bus64.in_a = 64'h1234_5678_9ABC_DEF0;
        bus64.in_b = 64'h5;
        bus64.in_tag = 3'd2;
        cycle();
        bus64.in_valid = 1'b0;
        @(negedge clk);
        check("x64_sll_valid", {63'b0, bus64.out_valid}, 64'h1);
        check("x64_sll_result", bus64.out_result, 64'h8000_0000_0000_0000);
        check("x64_sll_tag", {61'b0, bus64.out_tag}, 64'h1);
        cycle();
        @(negedge clk);
        check("x64_badop_valid", {63'b0, bus64.out_valid}, 64'h1);
        check("x64_badop_result", bus64.out_result, 64'h0);
        check("x64_badop_tag", {61'b0, bus64.out_tag}, 64'h2);
        cycle();
        @(negedge clk);
        check("x64_drained", {63'b0, bus64.out_valid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [4:0] st_rand_op(input int unsigned idx);
        case (idx)
            0:  return 5'b00000;
            1:  return 5'b00001;
            2:  return 5'b00010;
            3:  return 5'b00011;
            4:  return 5'b00100;
            5:  return 5'b00101;
            6:  return 5'b00110;
            7:  return 5'b00111;
            8:  return 5'b01000;
            9:  return 5'b01001;
            10: return 5'b01010;
            11: return 5'b01011;
            12: return 5'b01100;
            13: return 5'b01101;
            14: return 5'b10001;
            15: return 5'b11010;
            default: return 5'b11011;
        endcase
    endfunction

endmodule
